// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard scancode decoder.
// Decode states, prefix bytes, discard set and the 10-bit key event.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } state_e;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    // Keyboard status/ack replies, never part of a key sequence
    function automatic logic is_discard(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO for the PS/2 keyboard decoder.
// Push is accepted when full only if a pop happens in the same cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [EVT_W-1:0]         data_i,
    input  logic                     pop_i,
    output logic [EVT_W-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_MAX);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign cnt_o   = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scancode set 2 decoder: folds E0/F0 prefixes into key events.
// Optional inter-byte timeout is enabled by defining PS2_KBD_TIMEOUT_EN.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    i_byte,
    input  logic                          i_byte_vld,
    input  logic                          i_evt_rdy,
    output logic                          o_evt_vld,
    output logic [7:0]                    o_evt_code,
    output logic                          o_evt_ext,
    output logic                          o_evt_brk,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
    output logic                          o_ovf,
    input  logic                          i_ovf_clr,
    output logic                          o_tmo
);

    state_e           st_q;
    state_e           st_d;
    state_e           st_eff;
    logic             push;
    evt_t             evt;
    evt_t             head;
    logic [EVT_W-1:0] head_raw;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_q;
    logic             ovf_set;
    logic             expire;

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic          tmo_q;

    assign expire = (st_q != ST_IDLE) && (tcnt_q == TMO_LAST);

    always_comb begin
        tcnt_d = tcnt_q + 1'b1;
        if (i_byte_vld || expire || st_q == ST_IDLE) begin
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= expire;
        end
    end

    assign o_tmo = tmo_q;
`else
    assign expire = 1'b0;
    assign o_tmo  = 1'b0;
`endif

    // A strobe coinciding with expiry is decoded as if from IDLE
    always_comb begin
        st_eff = expire ? ST_IDLE : st_q;
        st_d   = st_eff;
        push   = 1'b0;
        evt    = '0;
        if (i_byte_vld) begin
            unique case (st_eff)
                ST_IDLE: begin
                    unique case (1'b1)
                        (i_byte == BYTE_E0): st_d = ST_GOT_E0;
                        (i_byte == BYTE_F0): st_d = ST_GOT_F0;
                        is_discard(i_byte):  st_d = ST_IDLE;
                        default: begin
                            push = 1'b1;
                            evt  = '{ext: 1'b0, brk: 1'b0, code: i_byte};
                        end
                    endcase
                end
                ST_GOT_E0: begin
                    unique case (1'b1)
                        (i_byte == BYTE_F0): st_d = ST_GOT_E0F0;
                        (i_byte == BYTE_E0): st_d = ST_GOT_E0;
                        is_discard(i_byte):  st_d = ST_IDLE;
                        default: begin
                            st_d = ST_IDLE;
                            push = 1'b1;
                            evt  = '{ext: 1'b1, brk: 1'b0, code: i_byte};
                        end
                    endcase
                end
                ST_GOT_F0, ST_GOT_E0F0: begin
                    st_d = ST_IDLE;
                    if (!(i_byte == BYTE_E0 || i_byte == BYTE_F0
                          || is_discard(i_byte))) begin
                        push = 1'b1;
                        evt  = '{ext: (st_eff == ST_GOT_E0F0),
                                 brk: 1'b1, code: i_byte};
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (evt),
        .pop_i   (i_evt_rdy),
        .data_o  (head_raw),
        .cnt_o   (o_fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ovf_set = push && fifo_full && !(i_evt_rdy && !fifo_empty);

    // Overflow wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign head       = evt_t'(head_raw);
    assign o_evt_vld  = !fifo_empty;
    assign o_evt_code = head.code;
    assign o_evt_ext  = head.ext;
    assign o_evt_brk  = head.brk;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: directed scancode sequences.
// Expected events are queued at stimulus time and checked on each pop.
module tb_ps2_kbd_ctrl;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_byte;
    logic       i_byte_vld;
    logic       i_evt_rdy;
    logic       o_evt_vld;
    logic [7:0] o_evt_code;
    logic       o_evt_ext;
    logic       o_evt_brk;
    logic [2:0] o_fifo_cnt;
    logic       o_ovf;
    logic       i_ovf_clr;
    logic       o_tmo;

    int   vectors     = 0;
    int   miscompares = 0;
    evt_t exp_q[$];

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_byte     (i_byte),
        .i_byte_vld (i_byte_vld),
        .i_evt_rdy  (i_evt_rdy),
        .o_evt_vld  (o_evt_vld),
        .o_evt_code (o_evt_code),
        .o_evt_ext  (o_evt_ext),
        .o_evt_brk  (o_evt_brk),
        .o_fifo_cnt (o_fifo_cnt),
        .o_ovf      (o_ovf),
        .i_ovf_clr  (i_ovf_clr),
        .o_tmo      (o_tmo)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        i_byte     = b;
        i_byte_vld = 1'b1;
        @(posedge clk);
        #1;
        i_byte_vld = 1'b0;
    endtask

    task automatic expect_evt(input logic ext, input logic brk,
                              input logic [7:0] code);
        exp_q.push_back('{ext: ext, brk: brk, code: code});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || o_fifo_cnt != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every handshake pops and compares against the queue
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_evt_vld && i_evt_rdy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL evt_unexpected: got %0h expected none",
                             {o_evt_ext, o_evt_brk, o_evt_code});
                end else begin
                    e = exp_q.pop_front();
                    check("evt", {o_evt_ext, o_evt_brk, o_evt_code}, e);
                end
            end
        end
    end

    initial begin
        int tmo_n;
        rst_n      = 1'b0;
        i_byte     = 8'h00;
        i_byte_vld = 1'b0;
        i_evt_rdy  = 1'b0;
        i_ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", o_evt_vld, 0);
        check("rst_cnt", o_fifo_cnt, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_tmo", o_tmo, 0);
        check("rst_code", o_evt_code, 0);
        rst_n = 1'b1;

        i_evt_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rdy_empty_cnt", o_fifo_cnt, 0);

        expect_evt(1'b0, 1'b0, 8'h1C);
        send(8'h1C);
        check("lat_1c_vld", o_evt_vld, 1);
        wait_drain("drain_1c");

        send(8'hE0);
        check("pre_e0_vld", o_evt_vld, 0);
        send(8'hF0);
        check("pre_f0_vld", o_evt_vld, 0);
        expect_evt(1'b1, 1'b1, 8'h75);
        send(8'h75);
        wait_drain("drain_75");

        send(8'hE0);
        send(8'hE0);
        expect_evt(1'b1, 1'b0, 8'h6C);
        send(8'h6C);
        send(8'hF0);
        expect_evt(1'b0, 1'b1, 8'h1C);
        send(8'h1C);
        wait_drain("drain_mix");

        send(8'hF0);
        send(8'hFA);
        check("f0fa_vld", o_evt_vld, 0);
        expect_evt(1'b0, 1'b0, 8'h16);
        send(8'h16);
        send(8'hE0);
        send(8'hAA);
        expect_evt(1'b0, 1'b0, 8'h29);
        send(8'h29);
        wait_drain("drain_disc");

        // Fill to depth, overflow with a coinciding clear request
        i_evt_rdy = 1'b0;
        expect_evt(1'b0, 1'b0, 8'h15);
        send(8'h15);
        expect_evt(1'b0, 1'b0, 8'h1D);
        send(8'h1D);
        expect_evt(1'b0, 1'b0, 8'h24);
        send(8'h24);
        expect_evt(1'b0, 1'b0, 8'h2D);
        send(8'h2D);
        @(posedge clk);
        #1;
        i_byte     = 8'h2C;
        i_byte_vld = 1'b1;
        i_ovf_clr  = 1'b1;
        @(posedge clk);
        #1;
        i_byte_vld = 1'b0;
        i_ovf_clr  = 1'b0;
        check("ovf_cnt", o_fifo_cnt, 4);
        check("ovf_set", o_ovf, 1);
        @(posedge clk);
        #1;
        i_ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        i_ovf_clr = 1'b0;
        check("ovf_clr", o_ovf, 0);
        check("ovf_keep_cnt", o_fifo_cnt, 4);

        // Push into a full FIFO alongside a pop is accepted
        @(posedge clk);
        #1;
        i_evt_rdy  = 1'b1;
        i_byte     = 8'h34;
        i_byte_vld = 1'b1;
        expect_evt(1'b0, 1'b0, 8'h34);
        @(posedge clk);
        #1;
        i_byte_vld = 1'b0;
        check("full_pop_cnt", o_fifo_cnt, 4);
        check("full_pop_ovf", o_ovf, 0);
        wait_drain("drain_ovf");

        tmo_n = 0;
        send(8'hE0);
        repeat (25) begin
            @(negedge clk);
            if (o_tmo) tmo_n++;
        end
`ifdef PS2_KBD_TIMEOUT_EN
        check("tmo_pulse", 32'(tmo_n), 1);
        expect_evt(1'b0, 1'b0, 8'h74);
`else
        check("tmo_none", 32'(tmo_n), 0);
        expect_evt(1'b1, 1'b0, 8'h74);
`endif
        send(8'h74);
        wait_drain("drain_74");

        send(8'hE0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", o_evt_vld, 0);
        check("mid_rst_cnt", o_fifo_cnt, 0);
        check("mid_rst_ovf", o_ovf, 0);
        check("mid_rst_tmo", o_tmo, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_evt(1'b0, 1'b0, 8'h6B);
        send(8'h6B);
        check("lat_6b_vld", o_evt_vld, 1);
        wait_drain("drain_6b");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
